// File: rtl/key_sequence_game_if.sv
// ---------------------------------------------------------------------------
// key_sequence_game_if
// Purpose : groups the keyboard input strobe and the game's visible outputs
//           into one bundle shared by the game core and its environment.
// Signals : key_code  [7:0]         PS/2 scan code byte
//           key_valid               one-cycle strobe qualifying key_code
//           led       [SEQ_LEN-1:0] thermometer progress
//           sel_seg   [7:0]         active-low digit select
//           seg       [6:0]         active-low segments {g,f,e,d,c,b,a}
//           win, lose               game result flags
// Modports: master drives keys and observes outputs; slave is the game core.
// ---------------------------------------------------------------------------
interface key_sequence_game_if #(
  parameter int SEQ_LEN = 6
);
  logic [7:0]         key_code;
  logic               key_valid;
  logic [SEQ_LEN-1:0] led;
  logic [7:0]         sel_seg;
  logic [6:0]         seg;
  logic               win;
  logic               lose;

  modport master (
    output key_code, key_valid,
    input  led, sel_seg, seg, win, lose
  );

  modport slave (
    input  key_code, key_valid,
    output led, sel_seg, seg, win, lose
  );
endinterface

// File: rtl/key_sequence_game.sv
// ---------------------------------------------------------------------------
// key_sequence_game
// Purpose : keyboard sequence game. The player must type the make codes in
//           SEQ in order before TIME_LIMIT seconds elapse and before
//           FAIL_LIMIT wrong keys. Progress is shown on led, elapsed time
//           (or PASS / FAIL) on a scanned 4-digit 7-segment display.
// Ports   : clk      system clock, rising edge
//           reset    synchronous, active-high reset
//           game_if  key_sequence_game_if.slave (key_code/key_valid in,
//                    led/sel_seg/seg/win/lose out, all registered)
// Options : define FAIL_COUNT_DISPLAY_EN to show the fail count in BCD on
//           digits 2..3 while playing (blank otherwise).
// ---------------------------------------------------------------------------
module key_sequence_game #(
  parameter int                   SEQ_LEN     = 6,
  parameter logic [8*SEQ_LEN-1:0] SEQ         = {8'h36, 8'h15, 8'h3b, 8'h36, 8'h36, 8'h36},
  parameter int                   CLK_HZ      = 100000000,
  parameter int                   TIME_LIMIT  = 30,
  parameter int                   FAIL_LIMIT  = 10,
  parameter int                   SCAN_CYCLES = 100000
) (
  input logic                clk,
  input logic                reset,
  key_sequence_game_if.slave game_if
);

  localparam int PW  = 4;  // progress, 0..8
  localparam int FW  = 4;  // fail count, 0..15
  localparam int SW  = 7;  // elapsed seconds, 0..99
  localparam int CW  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SCW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] ESC_CODE = 8'h76;

  localparam logic [6:0] G_BLANK = 7'h7F;
  localparam logic [6:0] G_P     = 7'b0001100;
  localparam logic [6:0] G_A     = 7'b0001000;
  localparam logic [6:0] G_S     = 7'b0010010;
  localparam logic [6:0] G_F     = 7'b0001110;
  localparam logic [6:0] G_I     = 7'b1111001;
  localparam logic [6:0] G_L     = 7'b1000111;

  typedef enum logic [1:0] {PLAY, WIN, LOSE} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    prog_q, prog_d;
  logic [FW-1:0]    fail_q, fail_d;
  logic [SW-1:0]    sec_q, sec_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [SCW-1:0]   scan_q, scan_d;
  logic [1:0]       digit_q, digit_d;
  logic             brk_q, brk_d;

  logic [SEQ_LEN-1:0] led_q, led_d;
  logic [7:0]         sel_seg_q, sel_seg_d;
  logic [6:0]         seg_q, seg_d;
  logic               win_q, win_d;
  logic               lose_q, lose_d;

  logic               make_key;
  logic [7:0]         sec_bcd;
`ifdef FAIL_COUNT_DISPLAY_EN
  logic [7:0]         fail_bcd;
`endif

  // SEQ byte at position idx, first key in the MSB byte.
  function automatic logic [7:0] seq_byte(input logic [PW-1:0] idx);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < SEQ_LEN; i++)
      if (idx == PW'(i)) b = SEQ[8*(SEQ_LEN-1-i) +: 8];
    return b;
  endfunction

  function automatic logic [7:0] to_bcd(input logic [SW-1:0] v);
    return {4'(v / SW'(10)), 4'(v % SW'(10))};
  endfunction

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return G_BLANK;
    endcase
  endfunction

  // A make code is any valid byte that is neither a break prefix nor the
  // byte discarded after one.
  assign make_key = game_if.key_valid && !brk_q && (game_if.key_code != BRK_CODE);

  // State register: all state and all outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q   <= PLAY;
      prog_q    <= '0;
      fail_q    <= '0;
      sec_q     <= '0;
      cyc_q     <= '0;
      scan_q    <= '0;
      digit_q   <= '0;
      brk_q     <= 1'b0;
      led_q     <= '0;
      sel_seg_q <= 8'hFF;
      seg_q     <= G_BLANK;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prog_q    <= prog_d;
      fail_q    <= fail_d;
      sec_q     <= sec_d;
      cyc_q     <= cyc_d;
      scan_q    <= scan_d;
      digit_q   <= digit_d;
      brk_q     <= brk_d;
      led_q     <= led_d;
      sel_seg_q <= sel_seg_d;
      seg_q     <= seg_d;
      win_q     <= win_d;
      lose_q    <= lose_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    state_d = state_q;
    prog_d  = prog_q;
    fail_d  = fail_q;
    sec_d   = sec_q;
    cyc_d   = cyc_q;
    brk_d   = brk_q;
    scan_d  = scan_q + SCW'(1);
    digit_d = digit_q;

    if (scan_q == SCW'(SCAN_CYCLES - 1)) begin
      scan_d  = '0;
      digit_d = digit_q + 2'd1;
    end

    if (game_if.key_valid) begin
      if (game_if.key_code == BRK_CODE) brk_d = 1'b1;
      else if (brk_q)                   brk_d = 1'b0;
    end

    case (state_q)
      PLAY: begin
        if (cyc_q == CW'(CLK_HZ - 1)) begin
          cyc_d = '0;
          sec_d = sec_q + SW'(1);
        end else begin
          cyc_d = cyc_q + CW'(1);
        end

        if (make_key) begin
          if (game_if.key_code == seq_byte(prog_q)) begin
            prog_d = prog_q + PW'(1);
          end else begin
            if (fail_q != FW'(FAIL_LIMIT)) fail_d = fail_q + FW'(1);
            // A wrong key may itself start a fresh attempt.
            prog_d = (game_if.key_code == seq_byte('0)) ? PW'(1) : PW'(0);
          end
        end

        // A completing key wins even if time or fails run out this cycle.
        if (prog_d == PW'(SEQ_LEN))
          state_d = WIN;
        else if (fail_d == FW'(FAIL_LIMIT) || sec_d == SW'(TIME_LIMIT))
          state_d = LOSE;
      end
      default: begin
        if (make_key && game_if.key_code == ESC_CODE) begin
          state_d = PLAY;
          prog_d  = '0;
          fail_d  = '0;
          sec_d   = '0;
          cyc_d   = '0;
        end
      end
    endcase
  end

  // Output logic, computed from next-state values so the registered outputs
  // line up with the registered state.
  always_comb begin
    sec_bcd = to_bcd(sec_d);
`ifdef FAIL_COUNT_DISPLAY_EN
    fail_bcd = to_bcd(SW'(fail_d));
`endif
    for (int i = 0; i < SEQ_LEN; i++) led_d[i] = (prog_d > PW'(i));
    win_d     = (state_d == WIN);
    lose_d    = (state_d == LOSE);
    sel_seg_d = ~(8'd1 << digit_d);
    seg_d     = G_BLANK;

    case (state_d)
      WIN: begin
        case (digit_d)
          2'd3:    seg_d = G_P;
          2'd2:    seg_d = G_A;
          default: seg_d = G_S;
        endcase
      end
      LOSE: begin
        case (digit_d)
          2'd3:    seg_d = G_F;
          2'd2:    seg_d = G_A;
          2'd1:    seg_d = G_I;
          default: seg_d = G_L;
        endcase
      end
      default: begin
        case (digit_d)
          2'd0:    seg_d = digit_glyph(sec_bcd[3:0]);
          2'd1:    seg_d = digit_glyph(sec_bcd[7:4]);
`ifdef FAIL_COUNT_DISPLAY_EN
          2'd2:    seg_d = digit_glyph(fail_bcd[3:0]);
          default: seg_d = digit_glyph(fail_bcd[7:4]);
`else
          default: seg_d = G_BLANK;
`endif
        endcase
      end
    endcase
  end

  assign game_if.led     = led_q;
  assign game_if.sel_seg = sel_seg_q;
  assign game_if.seg     = seg_q;
  assign game_if.win     = win_q;
  assign game_if.lose    = lose_q;

endmodule

// File: tb/tb_key_sequence_game.sv
// ---------------------------------------------------------------------------
// tb_key_sequence_game
// Bench for key_sequence_game with CLK_HZ=100, SCAN_CYCLES=4, SEQ_LEN=3,
// SEQ={36,15,3B}. Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_key_sequence_game;

  localparam int          SEQ_LEN     = 3;
  localparam logic [23:0] SEQ         = {8'h36, 8'h15, 8'h3B};
  localparam int          CLK_HZ      = 100;
  localparam int          TIME_LIMIT  = 30;
  localparam int          FAIL_LIMIT  = 10;
  localparam int          SCAN_CYCLES = 4;

  localparam logic [6:0] G_BLANK = 7'h7F;
  localparam logic [6:0] G_0     = 7'b1000000;
  localparam logic [6:0] G_1     = 7'b1111001;
  localparam logic [6:0] G_5     = 7'b0010010;
  localparam logic [6:0] G_P     = 7'b0001100;
  localparam logic [6:0] G_A     = 7'b0001000;
  localparam logic [6:0] G_S     = 7'b0010010;
  localparam logic [6:0] G_F     = 7'b0001110;
  localparam logic [6:0] G_I     = 7'b1111001;
  localparam logic [6:0] G_L     = 7'b1000111;
`ifdef FAIL_COUNT_DISPLAY_EN
  localparam logic [6:0] G_HI    = G_0;  // fail count 0 on digits 2..3
`else
  localparam logic [6:0] G_HI    = G_BLANK;
`endif

  typedef enum {D_NONE, D_PASS, D_LOSE, D_ZERO} disp_e;

  typedef struct {
    bit         rst;
    logic [7:0] key;
    logic [2:0] led;
    logic       win;
    logic       lose;
    disp_e      disp;
  } vec_t;

  typedef struct {
    logic [2:0] led;
    logic       win;
    logic       lose;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;
  int   tcount  = 0;  // rising edges since reset was released

  vec_t vecs[$];
  exp_t exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) tcount <= 0;
    else       tcount <= tcount + 1;
  end

  key_sequence_game_if #(.SEQ_LEN(SEQ_LEN)) game_if ();

  key_sequence_game #(
    .SEQ_LEN(SEQ_LEN), .SEQ(SEQ), .CLK_HZ(CLK_HZ), .TIME_LIMIT(TIME_LIMIT),
    .FAIL_LIMIT(FAIL_LIMIT), .SCAN_CYCLES(SCAN_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .game_if(game_if)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    game_if.key_valid = 1'b0;
    game_if.key_code  = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One byte per cycle: driven on a falling edge, sampled on the next rise.
  task automatic send_byte(input logic [7:0] code);
    game_if.key_valid = 1'b1;
    game_if.key_code  = code;
    @(negedge clk);
    game_if.key_valid = 1'b0;
    game_if.key_code  = 8'h00;
  endtask

  task automatic send_key(input logic [7:0] code);
    send_byte(code);
    send_byte(8'hF0);
    send_byte(code);
  endtask

  task automatic wait_count(input int n);
    int budget;
    budget = 5000;
    while (tcount < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check($sformatf("cycle_sync_%0d", n), tcount, n);
  endtask

  // Watch one full scan and compare every slot against its expected glyph.
  task automatic check_display(input string name, input logic [6:0] g3, g2, g1, g0);
    logic [6:0] exp_g [4];
    logic [3:0] seen;
    int         errs;
    int         d;
    exp_g[0] = g0; exp_g[1] = g1; exp_g[2] = g2; exp_g[3] = g3;
    seen = '0;
    errs = 0;
    for (int c = 0; c < 4 * SCAN_CYCLES; c++) begin
      @(negedge clk);
      d = -1;
      for (int k = 0; k < 4; k++)
        if (game_if.sel_seg == ~(8'd1 << k)) d = k;
      if (d < 0) errs++;
      else begin
        seen[d] = 1'b1;
        if (game_if.seg !== exp_g[d]) errs++;
      end
    end
    if (seen != 4'hF) errs++;
    check(name, errs, 0);
  endtask

  function automatic vec_t mk(bit rst, logic [7:0] key, logic [2:0] led,
                              logic win, logic lose, disp_e disp);
    vec_t v;
    v.rst = rst; v.key = key; v.led = led; v.win = win; v.lose = lose; v.disp = disp;
    return v;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;

    // Basic win, ignored key in WIN, Esc back to PLAY.
    vecs.push_back(mk(1, 8'h36, 3'b001, 0, 0, D_NONE));
    vecs.push_back(mk(0, 8'h15, 3'b011, 0, 0, D_NONE));
    vecs.push_back(mk(0, 8'h3B, 3'b111, 1, 0, D_PASS));
    vecs.push_back(mk(0, 8'h1C, 3'b111, 1, 0, D_NONE));
    vecs.push_back(mk(0, 8'h76, 3'b000, 0, 0, D_ZERO));
    // Mismatch that restarts the attempt at progress 1.
    vecs.push_back(mk(1, 8'h36, 3'b001, 0, 0, D_NONE));
    vecs.push_back(mk(0, 8'h36, 3'b001, 0, 0, D_NONE));
    vecs.push_back(mk(0, 8'h15, 3'b011, 0, 0, D_NONE));
    vecs.push_back(mk(0, 8'h3B, 3'b111, 1, 0, D_PASS));
    // Ten wrong keys lose; other keys ignored; Esc restarts.
    vecs.push_back(mk(1, 8'h36, 3'b001, 0, 0, D_NONE));
    for (int i = 1; i < FAIL_LIMIT; i++)
      vecs.push_back(mk(0, 8'h1C, 3'b000, 0, 0, D_NONE));
    vecs.push_back(mk(0, 8'h1C, 3'b000, 0, 1, D_LOSE));
    vecs.push_back(mk(0, 8'h36, 3'b000, 0, 1, D_NONE));
    vecs.push_back(mk(0, 8'h76, 3'b000, 0, 0, D_ZERO));

    // Reset state.
    do_reset();
    check("rst_led", game_if.led, 3'b000);
    check("rst_win", game_if.win, 1'b0);
    check("rst_lose", game_if.lose, 1'b0);
    check("rst_sel", game_if.sel_seg, 8'hFF);
    check("rst_seg", game_if.seg, G_BLANK);
    @(negedge clk);
    check("first_sel", game_if.sel_seg, 8'hFE);
    check("first_seg", game_if.seg, G_0);

    // Table-driven sequences through the scoreboard.
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      exp_q.push_back('{vecs[i].led, vecs[i].win, vecs[i].lose});
      send_key(vecs[i].key);
      if (exp_q.size() == 0) begin
        check($sformatf("v%0d_queue", i), 0, 1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("v%0d_led", i), game_if.led, e.led);
        check($sformatf("v%0d_win", i), game_if.win, e.win);
        check($sformatf("v%0d_lose", i), game_if.lose, e.lose);
      end
      case (vecs[i].disp)
        D_PASS:  check_display($sformatf("v%0d_disp_pass", i), G_P, G_A, G_S, G_S);
        D_LOSE:  check_display($sformatf("v%0d_disp_lose", i), G_F, G_A, G_I, G_L);
        D_ZERO:  check_display($sformatf("v%0d_disp_00", i), G_HI, G_HI, G_0, G_0);
        default: ;
      endcase
    end

    // Timeout: elapsed shows 15 midway, LOSE exactly at 30 s.
    do_reset();
    wait_count(1500);
    check_display("t15_disp", G_HI, G_HI, G_1, G_5);
    wait_count(TIME_LIMIT * CLK_HZ - 1);
    check("pre_timeout_lose", game_if.lose, 1'b0);
    @(negedge clk);
    check("timeout_lose", game_if.lose, 1'b1);
    check("timeout_win", game_if.win, 1'b0);
    check_display("timeout_disp", G_F, G_A, G_I, G_L);

    // Completing key in the timeout cycle wins.
    do_reset();
    send_key(8'h36);
    send_key(8'h15);
    check("race_led_pre", game_if.led, 3'b011);
    wait_count(TIME_LIMIT * CLK_HZ - 1);
    send_byte(8'h3B);
    check("race_cycle", tcount, TIME_LIMIT * CLK_HZ);
    check("race_win", game_if.win, 1'b1);
    check("race_lose", game_if.lose, 1'b0);
    check("race_led", game_if.led, 3'b111);

    // Reset with a key in the same cycle at progress 2.
    do_reset();
    send_key(8'h36);
    send_key(8'h15);
    check("rk_led_pre", game_if.led, 3'b011);
    reset = 1'b1;
    game_if.key_valid = 1'b1;
    game_if.key_code  = 8'h3B;
    @(negedge clk);
    check("rk_led", game_if.led, 3'b000);
    check("rk_sel", game_if.sel_seg, 8'hFF);
    check("rk_seg", game_if.seg, G_BLANK);
    check("rk_win", game_if.win, 1'b0);
    reset = 1'b0;
    game_if.key_valid = 1'b0;
    @(negedge clk);
    check("rk_led_after", game_if.led, 3'b000);
    check("rk_win_after", game_if.win, 1'b0);

    // Reset mid-break clears the break flag: next make code is accepted.
    send_byte(8'h36);
    check("mb_led_make", game_if.led, 3'b001);
    send_byte(8'hF0);
    reset = 1'b1;
    game_if.key_valid = 1'b1;
    game_if.key_code  = 8'h36;
    @(negedge clk);
    reset = 1'b0;
    game_if.key_valid = 1'b0;
    check("mb_led_rst", game_if.led, 3'b000);
    send_byte(8'h36);
    check("mb_led_after", game_if.led, 3'b001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
